encoder_4to2_seq: RTL and testbench
===================================

# encoder_4to2_seq

Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 one-hot decoder. It captures a 4-bit request vector, which may be multi-hot, and emits the 2-bit index of every set bit one at a time, highest index first, over a valid/ready handshake. It sits in front of the 2-to-4 decoder in loopback and test paths, so a multi-hot vector can be serialised into codes and re-expanded downstream.

## Interface
- No parameters. Widths are fixed at 4 input lines and a 2-bit code.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low. Sampled on the rising edge of clk.
- d  in  4  request vector; d[k]=1 requests emission of code k.
- load  in  1  capture strobe for d.
- i  out  2  current code. Held at 2'b00 when valid=0.
- valid  out  1  i is valid.
- ready  in  1  downstream accepts i this cycle.
- last  out  1  the current code is the final one of the batch. Only meaningful when valid=1.
- busy  out  1  a batch is in progress; equal to valid.
- none  out  1  one-cycle pulse: a load with d=4'b0000 was accepted.
- ovf  out  1  one-cycle pulse: a load arrived while busy and was dropped.

## Operation
- State: 4-bit pending mask `pend` and 2-state FSM (IDLE, EMIT). All outputs are decoded from registers only. There is no combinational path from d, load or ready to any output.
- Encoding:
  - i = index of highest set bit of pend: pend[3] gives 3, else pend[2] gives 2, else pend[1] gives 1, else pend[0] gives 0.
  - last = 1 when exactly one bit of pend is set.
- IDLE (valid=0, busy=0):
  - load=1 and d≠0: pend<=d, go to EMIT.
  - load=1 and d=0: none=1 on the next cycle, stay in IDLE.
  - load=0: hold.
- EMIT (valid=1, busy=1):
  - valid&ready with last=0: clear pend bit i, stay in EMIT.
  - valid&ready with last=1: pend<=0, go to IDLE. If load=1 in that same cycle, it is accepted exactly as in IDLE: next state EMIT with pend<=d, or IDLE with a none pulse when d=0. No ovf is raised.
  - ready=0: i, valid and last hold stable. This is required.
  - load=1 without a completing last handshake: d is ignored, ovf=1 on the next cycle, and pend is unchanged.
- The encoder never reorders codes, never skips a code and never repeats one. Each set bit of the captured d produces exactly one accepted code.
- Reset (rst_n=0 at an edge), including mid-batch:
  - pend=0, state=IDLE.
  - i=2'b00, valid=0, last=0, busy=0, none=0, ovf=0.
  - The pending batch is discarded. Inputs in the reset cycle are ignored.

## Timing
- Load-to-first-valid latency: 1 cycle. load is sampled at edge k, and valid=1 from edge k+1.
- Throughput: one code per cycle while ready=1.
- A batch of n set bits with ready held high:
  - codes are accepted at edges k+1..k+n;
  - valid falls after edge k+n unless a new load is accepted at that edge.
- A back-to-back load at the final handshake gives zero idle cycles between batches.
- none and ovf are high for exactly one cycle, the cycle after the triggering edge.
- Backpressure: ready may toggle freely. Only a cycle with valid&ready consumes a code.

## Test plan
- Reset, then single-hot inputs: load d=0001, 0010, 0100, 1000 in turn, with ready=1 → i=0, 1, 2, 3 respectively, valid for exactly 1 cycle each, last=1 each time.
- Multi-hot with ready held high: load d=1111 → i=3, 2, 1, 0 on 4 consecutive cycles, last=1 only on i=0, then valid=0. Load d=1010 → i=3 then i=1.
- Backpressure: load d=0110 with ready=0 for 3 cycles → i=2, valid=1 and last=0 stable throughout. Then ready=1 → i=2 is accepted, followed by i=1 with last=1.
- Loads in EMIT:
  - load d=0001 while the batch from d=1100 is still at i=3 → ovf pulse; the batch still yields exactly 3 then 2.
  - load d=0011 in the same cycle as the final handshake → no ovf; next cycles yield i=1, 0 with no gap.
- Zero vector: load d=0000 in IDLE → none pulses for 1 cycle, valid stays 0, busy stays 0.
- Reset mid-batch: load d=1111, accept one code, then assert rst_n=0 for 1 cycle → all outputs 0 after the edge. A subsequent load of d=0100 yields only i=2.

Source files
------------

// File: rtl/encoder_4to2_seq.sv
// Sequential 4-to-2 encoder: serialises a multi-hot request
// vector into 2-bit codes, highest index first, over valid/ready.
module encoder_4to2_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d,
   input  logic       load,
   output logic [1:0] i,
   output logic       valid,
   input  logic       ready,
   output logic       last,
   output logic       busy,
   output logic       none,
   output logic       ovf
);

   typedef enum logic {
      S_IDLE,
      S_EMIT
   } state_t;

   state_t     r_state;
   state_t     w_nxt_state;
   logic [3:0] r_pend;
   logic [3:0] w_nxt_pend;
   logic [3:0] w_clr;
   logic [1:0] r_i;
   logic       r_valid;
   logic       r_last;
   logic       r_none;
   logic       r_ovf;
   logic       w_take;
   logic       w_none;
   logic       w_ovf;

   function automatic logic [1:0] f_top(input logic [3:0] p);
      if (p[3])      return 2'd3;
      else if (p[2]) return 2'd2;
      else if (p[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   function automatic logic f_one(input logic [3:0] p);
      return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
   endfunction

   // Next pending mask, next state and the pulse conditions.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pend  = r_pend;
      w_take      = 1'b0;
      w_none      = 1'b0;
      w_ovf       = 1'b0;
      w_clr       = 4'b0001 << r_i;
      unique case (r_state)
         S_IDLE: begin
            w_take = load;
         end
         S_EMIT: begin
            if (ready && r_last) begin
               w_nxt_pend  = 4'd0;
               w_nxt_state = S_IDLE;
               w_take      = load;
            end else begin
               if (ready)
                  w_nxt_pend = r_pend & ~w_clr;
               w_ovf = load;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
      if (w_take) begin
         if (d != 4'd0) begin
            w_nxt_pend  = d;
            w_nxt_state = S_EMIT;
         end else begin
            w_none = 1'b1;
         end
      end
   end

   // State, mask and all outputs registered from the next mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pend  <= 4'd0;
         r_i     <= 2'd0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_none  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_pend  <= w_nxt_pend;
         r_i     <= f_top(w_nxt_pend);
         r_valid <= (w_nxt_state == S_EMIT);
         r_last  <= f_one(w_nxt_pend);
         r_none  <= w_none;
         r_ovf   <= w_ovf;
      end
   end

   assign i     = r_i;
   assign valid = r_valid;
   assign last  = r_last;
   assign busy  = r_valid;
   assign none  = r_none;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Bench for encoder_4to2_seq: directed vector table plus
// random traffic against a queue-of-codes reference model.
module tb_encoder_4to2_seq;

   logic       clk;
   logic       rst_n;
   logic [3:0] d;
   logic       load;
   logic [1:0] i;
   logic       valid;
   logic       ready;
   logic       last;
   logic       busy;
   logic       none;
   logic       ovf;

   int checks;
   int errors;

   int q[$];
   bit e_none;
   bit e_ovf;

   typedef struct {
      logic       rn;
      logic [3:0] d;
      logic       ld;
      logic       rd;
      logic [1:0] ei;
      logic       ev;
      logic       el;
      logic       enone;
      logic       eovf;
   } vec_t;

   vec_t tv[$];

   encoder_4to2_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .load  (load),
      .i     (i),
      .valid (valid),
      .ready (ready),
      .last  (last),
      .busy  (busy),
      .none  (none),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d",
                  nm, $time, act, exp);
      end
   endtask

   task automatic model(input logic rn, input logic [3:0] dv,
                        input logic ld, input logic rd);
      bit was_busy;
      bit fin;
      e_none = 1'b0;
      e_ovf  = 1'b0;
      if (!rn) begin
         q.delete();
      end else begin
         was_busy = (q.size() > 0);
         fin      = (q.size() == 1) && rd;
         if (was_busy && rd)
            void'(q.pop_front());
         if (ld) begin
            if (!was_busy || fin) begin
               if (dv == 4'd0) e_none = 1'b1;
               for (int k = 3; k >= 0; k--)
                  if (dv[k]) q.push_back(k);
            end else begin
               e_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic cyc(input logic rn, input logic [3:0] dv,
                      input logic ld, input logic rd);
      int ei;
      rst_n = rn;
      d     = dv;
      load  = ld;
      ready = rd;
      @(posedge clk);
      model(rn, dv, ld, rd);
      #1;
      ei = (q.size() > 0) ? q[0] : 0;
      chk("valid", int'(valid), int'(q.size() > 0));
      chk("busy",  int'(busy),  int'(q.size() > 0));
      chk("code",  int'(i),     ei);
      if (q.size() > 0)
         chk("last", int'(last), int'(q.size() == 1));
      chk("none",  int'(none),  int'(e_none));
      chk("ovf",   int'(ovf),   int'(e_ovf));
   endtask

   function automatic vec_t mk(logic rn, logic [3:0] dv, logic ld,
                               logic rd, logic [1:0] ei, logic ev,
                               logic el, logic en, logic eo);
      vec_t v;
      v.rn = rn; v.d = dv; v.ld = ld; v.rd = rd;
      v.ei = ei; v.ev = ev; v.el = el;
      v.enone = en; v.eovf = eo;
      return v;
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      d      = 4'd0;
      load   = 1'b0;
      ready  = 1'b0;

      // reset
      tv.push_back(mk(0, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // single-hot
      tv.push_back(mk(1, 4'b0001, 1, 1, 0, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 4'b0010, 1, 1, 1, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 4'b0100, 1, 1, 2, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 4'b1000, 1, 1, 3, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // 1111
      tv.push_back(mk(1, 4'b1111, 1, 1, 3, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 2, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 1, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // 1010
      tv.push_back(mk(1, 4'b1010, 1, 1, 3, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 1, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // backpressure 0110
      tv.push_back(mk(1, 4'b0110, 1, 0, 2, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 0, 2, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 0, 2, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 0, 2, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 1, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // overflow load mid-batch
      tv.push_back(mk(1, 4'b1100, 1, 1, 3, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0001, 1, 0, 3, 1, 0, 0, 1));
      tv.push_back(mk(1, 4'b0000, 0, 1, 2, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // back-to-back at final handshake
      tv.push_back(mk(1, 4'b1100, 1, 1, 3, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 2, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0011, 1, 1, 1, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // zero vector
      tv.push_back(mk(1, 4'b0000, 1, 1, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
      // reset mid-batch, load in reset cycle ignored
      tv.push_back(mk(1, 4'b1111, 1, 1, 3, 1, 0, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 2, 1, 0, 0, 0));
      tv.push_back(mk(0, 4'b0100, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 4'b0100, 1, 1, 2, 1, 1, 0, 0));
      tv.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0));

      foreach (tv[n]) begin
         cyc(tv[n].rn, tv[n].d, tv[n].ld, tv[n].rd);
         chk("tv_code",  int'(i),     int'(tv[n].ei));
         chk("tv_valid", int'(valid), int'(tv[n].ev));
         chk("tv_busy",  int'(busy),  int'(tv[n].ev));
         if (tv[n].ev)
            chk("tv_last", int'(last), int'(tv[n].el));
         chk("tv_none",  int'(none),  int'(tv[n].enone));
         chk("tv_ovf",   int'(ovf),   int'(tv[n].eovf));
      end

      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 63) != 0),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
